spi_cmd_tx: RTL and testbench

//  SD-card SPI-mode command framer/responder used by the SPI driver during init (CMD0/CMD8) and

---
 rtl/spi_cmd_tx.sv | 182 ++++++++++++++++++
 tb/tb_spi_cmd_tx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_tx.sv
// SD-card SPI-mode command framer: shifts a 48-bit command frame on MOSI, then hunts/captures R1.
// Define SPI_CMD_CRC_EN to compute crc7 serially; otherwise crc7 comes from a CMD0/CMD8 table.
module spi_cmd_tx #(
  parameter int NCR_MAX   = 8,
  parameter int NCR_WIDTH = $clog2(NCR_MAX*8+1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk_rise_i,
  input  logic        sclk_fall_i,
  input  logic        cmd_valid_i,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] cmd_arg_i,
  output logic        cmd_ready_o,
  input  logic        miso_i,
  output logic        mosi_o,
  output logic        resp_valid_o,
  output logic [7:0]  resp_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CRC, S_SHIFT, S_WAIT, S_RECV, S_DONE
  } state_t;

  state_t state, state_n;

  logic [47:0]          shreg, shreg_n;
  logic [5:0]           bit_cnt, bit_cnt_n;
  logic [NCR_WIDTH-1:0] wait_cnt, wait_n;
  logic [3:0]           rx_cnt, rx_n;
  logic [7:0]           resp_n;
  logic                 to_n;
  logic [39:0]          frame40;
  logic                 rise, fall;

  localparam logic [NCR_WIDTH-1:0] WAIT_LAST = NCR_WIDTH'(NCR_MAX*8-1);

  assign rise    = sclk_rise_i;
  assign fall    = sclk_fall_i & ~sclk_rise_i;
  assign frame40 = {2'b01, cmd_index_i, cmd_arg_i};

`ifdef SPI_CMD_CRC_EN
  logic [6:0] crc, crc_n, crc_step;
  logic [5:0] crc_cnt, crc_cnt_n;
  logic       crc_fb;

  always_comb begin
    crc_fb   = crc[6] ^ shreg[6'd47 - crc_cnt];
    crc_step = {crc[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
  end

  // start bit must stay hidden until the crc is folded into the frame
  assign mosi_o = shreg[47] | (state == S_CRC);
`else
  logic [6:0] crc_tab;

  always_comb begin
    case (cmd_index_i)
      6'd0:    crc_tab = 7'h4A;
      6'd8:    crc_tab = 7'h43;
      default: crc_tab = 7'h7F;
    endcase
  end

  assign mosi_o = shreg[47];
`endif

  assign cmd_ready_o  = (state == S_IDLE);
  assign resp_valid_o = (state == S_DONE);

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    wait_n    = wait_cnt;
    rx_n      = rx_cnt;
    resp_n    = resp_o;
    to_n      = timeout_o;
`ifdef SPI_CMD_CRC_EN
    crc_n     = crc;
    crc_cnt_n = crc_cnt;
`endif
    unique case (state)
      S_IDLE: begin
        if (cmd_valid_i) begin
          bit_cnt_n = '0;
          wait_n    = '0;
          rx_n      = '0;
          to_n      = 1'b0;
          resp_n    = 8'hFF;
`ifdef SPI_CMD_CRC_EN
          shreg_n   = {frame40, 8'h01};
          crc_n     = '0;
          crc_cnt_n = '0;
          state_n   = S_CRC;
`else
          shreg_n   = {frame40, crc_tab, 1'b1};
          state_n   = S_SHIFT;
`endif
        end
      end
`ifdef SPI_CMD_CRC_EN
      S_CRC: begin
        crc_n     = crc_step;
        crc_cnt_n = crc_cnt + 6'd1;
        if (crc_cnt == 6'd39) begin
          shreg_n[7:1] = crc_step;
          state_n      = S_SHIFT;
        end
      end
`endif
      S_SHIFT: begin
        if (rise) begin
          bit_cnt_n = bit_cnt + 6'd1;
          if (bit_cnt == 6'd47) state_n = S_WAIT;
        end else if (fall) begin
          // ones shift in behind the frame so MOSI idles high afterwards
          shreg_n = {shreg[46:0], 1'b1};
        end
      end
      S_WAIT: begin
        if (rise) begin
          if (!miso_i) begin
            resp_n  = {resp_o[6:0], 1'b0};
            rx_n    = 4'd1;
            state_n = S_RECV;
          end else begin
            wait_n = wait_cnt + NCR_WIDTH'(1);
            if (wait_cnt == WAIT_LAST) begin
              to_n    = 1'b1;
              resp_n  = 8'hFF;
              state_n = S_DONE;
            end
          end
        end
      end
      S_RECV: begin
        if (rise) begin
          resp_n = {resp_o[6:0], miso_i};
          rx_n   = rx_cnt + 4'd1;
          if (rx_cnt == 4'd7) state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      shreg     <= '1;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      rx_cnt    <= '0;
      resp_o    <= 8'hFF;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bit_cnt   <= bit_cnt_n;
      wait_cnt  <= wait_n;
      rx_cnt    <= rx_n;
      resp_o    <= resp_n;
      timeout_o <= to_n;
    end
  end

`ifdef SPI_CMD_CRC_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc     <= '0;
      crc_cnt <= '0;
    end else begin
      crc     <= crc_n;
      crc_cnt <= crc_cnt_n;
    end
  end
`endif

endmodule

// File: tb/tb_spi_cmd_tx.sv
// Self-checking bench for spi_cmd_tx: frame/response model plus literal frame and R1 pins.
module tb_spi_cmd_tx;

  localparam int NCR_MAX = 8;

`ifdef SPI_CMD_CRC_EN
  localparam logic [7:0] CMD55_LAST = 8'h65;
`else
  localparam logic [7:0] CMD55_LAST = 8'hFF;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sclk_rise_i = 1'b0;
  logic        sclk_fall_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic [5:0]  cmd_index_i = '0;
  logic [31:0] cmd_arg_i = '0;
  logic        cmd_ready_o;
  logic        miso_i = 1'b1;
  logic        mosi_o;
  logic        resp_valid_o;
  logic [7:0]  resp_o;
  logic        timeout_o;

  always #5 clk = ~clk;

  spi_cmd_tx #(.NCR_MAX(NCR_MAX)) dut (
    .clk(clk), .rst(rst),
    .sclk_rise_i(sclk_rise_i), .sclk_fall_i(sclk_fall_i),
    .cmd_valid_i(cmd_valid_i), .cmd_index_i(cmd_index_i),
    .cmd_arg_i(cmd_arg_i), .cmd_ready_o(cmd_ready_o),
    .miso_i(miso_i), .mosi_o(mosi_o),
    .resp_valid_o(resp_valid_o), .resp_o(resp_o),
    .timeout_o(timeout_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic       exp_mosi = 1'b1;
  logic       exp_ready = 1'b1;
  logic       exp_valid = 1'b0;
  logic       exp_to = 1'b0;
  logic [7:0] exp_resp = 8'hFF;
  bit         chk_en = 1'b0;

  task automatic check(input string name, input logic [47:0] act,
                       input logic [47:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // frame from the command rules: {01,index,arg,crc7,1}
  function automatic logic [47:0] frame_of(input logic [5:0] idx,
                                           input logic [31:0] arg);
    logic [39:0] f;
    logic [6:0]  c;
    f = {2'b01, idx, arg};
    c = '0;
`ifdef SPI_CMD_CRC_EN
    for (int i = 39; i >= 0; i--) begin
      if (c[6] ^ f[i]) c = {c[5:0], 1'b0} ^ 7'h09;
      else             c = {c[5:0], 1'b0};
    end
`else
    if (idx == 6'd0)      c = 7'h4A;
    else if (idx == 6'd8) c = 7'h43;
    else                  c = 7'h7F;
`endif
    return {f, c, 1'b1};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("mosi", 48'(mosi_o), 48'(exp_mosi));
      check("ready", 48'(cmd_ready_o), 48'(exp_ready));
      check("valid", 48'(resp_valid_o), 48'(exp_valid));
      check("timeout", 48'(timeout_o), 48'(exp_to));
      if (exp_ready || exp_valid)
        check("resp", 48'(resp_o), 48'(exp_resp));
    end
  end

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg,
                         input int offset, input logic [7:0] r1,
                         input bit stuck, input bit hold,
                         input int abort_at, output logic [47:0] cap);
    logic [47:0] fr;
    int          done_k;
    int          j;
    bit          fin;
    bit          tmo;
    fr  = frame_of(idx, arg);
    cap = '0;
    fin = 1'b0;
    tmo = stuck || (offset >= NCR_MAX*8);
    cmd_index_i = idx;
    cmd_arg_i   = arg;
    cmd_valid_i = 1'b1;
    tick();
    if (!hold) cmd_valid_i = 1'b0;
    exp_ready = 1'b0;
    exp_to    = 1'b0;
    exp_resp  = 8'hFF;
`ifdef SPI_CMD_CRC_EN
    exp_mosi = 1'b1;
    repeat (40) tick();
`endif
    exp_mosi = fr[47];
    for (int i = 0; i < 48; i++) begin
      if (i == abort_at) begin
        exp_mosi    = 1'b1;
        exp_ready   = 1'b1;
        exp_valid   = 1'b0;
        cmd_valid_i = 1'b0;
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        return;
      end
      cap = {cap[46:0], mosi_o};
      sclk_rise_i = 1'b1;
      tick();
      sclk_rise_i = 1'b0;
      tick();
      sclk_fall_i = 1'b1;
      tick();
      sclk_fall_i = 1'b0;
      exp_mosi = (i < 47) ? fr[46-i] : 1'b1;
      tick();
    end
    cmd_valid_i = 1'b0;
    done_k = tmo ? NCR_MAX*8-1 : offset + 7;
    for (int k = 0; k < NCR_MAX*8 + 16 && !fin; k++) begin
      j = k - offset;
      if (stuck || j < 0 || j > 7) miso_i = 1'b1;
      else                         miso_i = r1[7-j];
      sclk_rise_i = 1'b1;
      tick();
      sclk_rise_i = 1'b0;
      if (k == done_k) begin
        exp_valid = 1'b1;
        exp_resp  = tmo ? 8'hFF : r1;
        exp_to    = tmo;
        tick();
        exp_valid = 1'b0;
        exp_ready = 1'b1;
        fin = 1'b1;
      end else begin
        tick();
        sclk_fall_i = 1'b1;
        tick();
        sclk_fall_i = 1'b0;
        tick();
      end
    end
    miso_i = 1'b1;
  endtask

  initial begin
    logic [47:0] cap;
    repeat (2) tick();
    check("rst_ready", 48'(cmd_ready_o), 48'h1);
    check("rst_mosi", 48'(mosi_o), 48'h1);
    check("rst_valid", 48'(resp_valid_o), 48'h0);
    check("rst_resp", 48'(resp_o), 48'hFF);
    check("rst_timeout", 48'(timeout_o), 48'h0);
    rst = 1'b1;
    chk_en = 1'b1;
    tick();

    run_cmd(6'd0, 32'h0, 16, 8'h01, 0, 0, -1, cap);
    check("cmd0_frame", cap, 48'h40_0000_0000_95);
    check("cmd0_r1", 48'(resp_o), 48'h01);
    check("cmd0_to", 48'(timeout_o), 48'h0);

    run_cmd(6'd8, 32'h1AA, 0, 8'h01, 0, 0, -1, cap);
    check("cmd8_frame", cap, 48'h48_0000_01AA_87);
    check("cmd8_r1", 48'(resp_o), 48'h01);

    run_cmd(6'd55, 32'h0, 5, 8'h01, 0, 0, -1, cap);
    check("cmd55_last", 48'(cap[7:0]), 48'(CMD55_LAST));
    check("cmd55_first", 48'(cap[47:40]), 48'h77);

    run_cmd(6'd17, 32'h200, 0, 8'h00, 1, 0, -1, cap);
    check("stuck_to", 48'(timeout_o), 48'h1);
    check("stuck_resp", 48'(resp_o), 48'hFF);

    run_cmd(6'd16, 32'h200, 3, 8'h05, 0, 0, -1, cap);
    check("offs3_r1", 48'(resp_o), 48'h05);
    check("offs3_to", 48'(timeout_o), 48'h0);

    run_cmd(6'd24, 32'hDEADBEEF, 1, 8'h00, 0, 1, -1, cap);
    check("hold_frame", cap, frame_of(6'd24, 32'hDEADBEEF));
    check("hold_r1", 48'(resp_o), 48'h00);

    run_cmd(6'd0, 32'h0, 0, 8'h01, 0, 0, 20, cap);
    check("abort_ready", 48'(cmd_ready_o), 48'h1);
    check("abort_mosi", 48'(mosi_o), 48'h1);

    run_cmd(6'd8, 32'h1AA, 2, 8'h09, 0, 0, -1, cap);
    check("recov_frame", cap, 48'h48_0000_01AA_87);
    check("recov_r1", 48'(resp_o), 48'h09);

    repeat (3) tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
